fetch_decode_queue: RTL and testbench

Parametrised multi-lane instruction queue between fetch and decode, replacing the fixed two-lane fetch/decode pipeline register. Fetch pushes up to LANES instructions per cycle. Decode sees the oldest LANES entries and retires any number of them per cycle. A flush input discards all buffered instructions, for redirects. DEPTH entries of buffering decouple fetch stalls from decode stalls.

---
 rtl/fetch_decode_queue_if.sv | 27 ++
 rtl/fetch_decode_queue.sv | 101 ++++++++++
 tb/tb_fetch_decode_queue.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_decode_queue: per-lane push from fetch, oldest-lanes view and retire count for decode.
interface fetch_decode_queue_if #(
  parameter int LANES = 2,
  parameter int DEPTH = 8
);
  logic [LANES-1:0]             ValidF;
  logic [32*LANES-1:0]          PCF;
  logic [32*LANES-1:0]          PCPlus4F;
  logic [32*LANES-1:0]          InstrF;
  logic                         ReadyF;
  logic [$clog2(LANES+1)-1:0]   PopCntD;
  logic [LANES-1:0]             ValidD;
  logic [32*LANES-1:0]          PCD;
  logic [32*LANES-1:0]          PCPlus4D;
  logic [32*LANES-1:0]          InstrD;
  logic [$clog2(DEPTH+1)-1:0]   CountD;

  modport master (
    output ValidF, PCF, PCPlus4F, InstrF, PopCntD,
    input  ReadyF, ValidD, PCD, PCPlus4D, InstrD, CountD
  );

  modport slave (
    input  ValidF, PCF, PCPlus4F, InstrF, PopCntD,
    output ReadyF, ValidD, PCD, PCPlus4D, InstrD, CountD
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Multi-lane circular instruction queue between fetch and decode with flush.
// Define FETCH_QUEUE_BYPASS_EN to let a push into an empty queue reach decode in the same cycle.
module fetch_decode_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  input logic flush,
  fetch_decode_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = $clog2(LANES+1);

  logic [31:0]   pcMem    [DEPTH];
  logic [31:0]   pc4Mem   [DEPTH];
  logic [31:0]   instrMem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [NW-1:0] pushCnt;
  logic [NW-1:0] pushAcc;
  logic [NW-1:0] visCnt;
  logic [NW-1:0] popEff;
  logic          runOn;
  logic          ready;
`ifdef FETCH_QUEUE_BYPASS_EN
  logic          bypassOn;
`endif

  // Only the unbroken run of valid lanes from lane 0 is pushed.
  always_comb begin
    pushCnt = '0;
    runOn   = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (runOn && q.ValidF[i]) pushCnt = pushCnt + NW'(1);
      else                      runOn   = 1'b0;
    end
  end

  assign ready    = (count <= CW'(DEPTH - LANES)) && !rst && !flush;
  assign pushAcc  = ready ? pushCnt : '0;
  assign q.ReadyF = ready;
  assign q.CountD = count;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypassOn = (count == '0) && (pushAcc != '0);
`endif

  always_comb begin
    visCnt = (count >= CW'(LANES)) ? NW'(LANES) : NW'(count);
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypassOn) visCnt = pushAcc;
`endif
    popEff     = (q.PopCntD < visCnt) ? q.PopCntD : visCnt;
    q.ValidD   = '0;
    q.PCD      = '0;
    q.PCPlus4D = '0;
    q.InstrD   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (visCnt > NW'(i)) begin
        q.ValidD[i]            = 1'b1;
        q.PCD[32*i +: 32]      = pcMem[head + PW'(i)];
        q.PCPlus4D[32*i +: 32] = pc4Mem[head + PW'(i)];
        q.InstrD[32*i +: 32]   = instrMem[head + PW'(i)];
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypassOn) begin
          q.PCD[32*i +: 32]      = q.PCF[32*i +: 32];
          q.PCPlus4D[32*i +: 32] = q.PCPlus4F[32*i +: 32];
          q.InstrD[32*i +: 32]   = q.InstrF[32*i +: 32];
        end
`endif
      end
    end
  end

  // Storage is never cleared; pushAcc is already zero under rst or flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (NW'(i) < pushAcc) begin
        pcMem[tail + PW'(i)]    <= q.PCF[32*i +: 32];
        pc4Mem[tail + PW'(i)]   <= q.PCPlus4F[32*i +: 32];
        instrMem[tail + PW'(i)] <= q.InstrF[32*i +: 32];
      end
    end
  end

  // Bypassed lanes that decode retires at once are written then skipped by head.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PW'(pushAcc);
      head  <= head + PW'(popEff);
      count <= count + CW'(pushAcc) - CW'(popEff);
    end
  end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed table-driven bench for fetch_decode_queue (LANES=2, DEPTH=8) plus wrap, flush and bypass sequences.
module tb_fetch_decode_queue;
  localparam int LANES = 2;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  fetch_decode_queue_if #(.LANES(LANES), .DEPTH(DEPTH)) bus ();

  fetch_decode_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .q     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  validF;
    logic [31:0] pcBase;
    logic [1:0]  pop;
    logic        fl;
    int          expCount;
    logic [1:0]  expValid;
    logic [31:0] expPc0;
    logic [31:0] expPc1;
    logic        expReady;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input logic [1:0] v, input logic [31:0] base, input logic [1:0] pop,
                                 input logic fl, input int cnt, input logic [1:0] ev,
                                 input logic [31:0] p0, input logic [31:0] p1, input logic rdy);
    vec_t r;
    r.validF = v;   r.pcBase = base; r.pop = pop;     r.fl = fl;
    r.expCount = cnt; r.expValid = ev; r.expPc0 = p0; r.expPc1 = p1; r.expReady = rdy;
    return r;
  endfunction

  // Instruction word tagged by its PC so misordered data is visible.
  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return 32'h00100093 + (pc << 18);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveLanes(input logic [1:0] v, input logic [31:0] base);
    bus.ValidF = v;
    for (int i = 0; i < LANES; i++) begin
      bus.PCF[32*i +: 32]      = base + 32'(4*i);
      bus.PCPlus4F[32*i +: 32] = base + 32'(4*i) + 32'd4;
      bus.InstrF[32*i +: 32]   = instrOf(base + 32'(4*i));
    end
  endtask

  task automatic idle();
    bus.ValidF  = '0;
    bus.PopCntD = '0;
    flush       = 1'b0;
  endtask

  // Inputs are held across one rising edge, then released before the outputs are sampled.
  task automatic applyStimulus(input vec_t v);
    driveLanes(v.validF, v.pcBase);
    bus.PopCntD = v.pop;
    flush       = v.fl;
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic checkState(input string tag, input int cnt, input logic [1:0] ev,
                            input logic [31:0] p0, input logic [31:0] p1, input logic rdy);
    checkOutput($sformatf("%s/count", tag),  32'(bus.CountD), 32'(cnt));
    checkOutput($sformatf("%s/valid", tag),  32'(bus.ValidD), 32'(ev));
    checkOutput($sformatf("%s/ready", tag),  32'(bus.ReadyF), 32'(rdy));
    checkOutput($sformatf("%s/pc0", tag),    bus.PCD[31:0],  ev[0] ? p0 : 32'h0);
    checkOutput($sformatf("%s/pc1", tag),    bus.PCD[63:32], ev[1] ? p1 : 32'h0);
    checkOutput($sformatf("%s/pc4_0", tag),  bus.PCPlus4D[31:0],  ev[0] ? p0 + 32'd4 : 32'h0);
    checkOutput($sformatf("%s/pc4_1", tag),  bus.PCPlus4D[63:32], ev[1] ? p1 + 32'd4 : 32'h0);
    checkOutput($sformatf("%s/instr0", tag), bus.InstrD[31:0],  ev[0] ? instrOf(p0) : 32'h0);
    checkOutput($sformatf("%s/instr1", tag), bus.InstrD[63:32], ev[1] ? instrOf(p1) : 32'h0);
  endtask

  initial begin
    //                 validF base      pop  fl  cnt valid  pc0       pc1       rdy
    vecs.push_back(mkVec(2'b11, 32'h00, 2'd0, 0, 2, 2'b11, 32'h00, 32'h04, 1));
    vecs.push_back(mkVec(2'b10, 32'h08, 2'd0, 0, 2, 2'b11, 32'h00, 32'h04, 1));
    vecs.push_back(mkVec(2'b01, 32'h08, 2'd0, 0, 3, 2'b11, 32'h00, 32'h04, 1));
    vecs.push_back(mkVec(2'b11, 32'h0C, 2'd0, 0, 5, 2'b11, 32'h00, 32'h04, 1));
    vecs.push_back(mkVec(2'b11, 32'h14, 2'd0, 0, 7, 2'b11, 32'h00, 32'h04, 0));
    vecs.push_back(mkVec(2'b11, 32'h1C, 2'd0, 0, 7, 2'b11, 32'h00, 32'h04, 0));
    vecs.push_back(mkVec(2'b00, 32'h00, 2'd2, 0, 5, 2'b11, 32'h08, 32'h0C, 1));
    vecs.push_back(mkVec(2'b11, 32'h1C, 2'd1, 0, 6, 2'b11, 32'h0C, 32'h10, 1));
    vecs.push_back(mkVec(2'b11, 32'h24, 2'd0, 0, 8, 2'b11, 32'h0C, 32'h10, 0));
    vecs.push_back(mkVec(2'b11, 32'h2C, 2'd0, 0, 8, 2'b11, 32'h0C, 32'h10, 0));
    vecs.push_back(mkVec(2'b00, 32'h00, 2'd2, 0, 6, 2'b11, 32'h14, 32'h18, 1));
    vecs.push_back(mkVec(2'b00, 32'h00, 2'd2, 0, 4, 2'b11, 32'h1C, 32'h20, 1));
    vecs.push_back(mkVec(2'b00, 32'h00, 2'd2, 0, 2, 2'b11, 32'h24, 32'h28, 1));
    vecs.push_back(mkVec(2'b00, 32'h00, 2'd1, 0, 1, 2'b01, 32'h28, 32'h00, 1));
    vecs.push_back(mkVec(2'b00, 32'h00, 2'd2, 0, 0, 2'b00, 32'h00, 32'h00, 1));
    vecs.push_back(mkVec(2'b00, 32'h00, 2'd2, 0, 0, 2'b00, 32'h00, 32'h00, 1));
    vecs.push_back(mkVec(2'b11, 32'h40, 2'd0, 0, 2, 2'b11, 32'h40, 32'h44, 1));
    vecs.push_back(mkVec(2'b11, 32'h48, 2'd0, 0, 4, 2'b11, 32'h40, 32'h44, 1));
    vecs.push_back(mkVec(2'b11, 32'h50, 2'd0, 0, 6, 2'b11, 32'h40, 32'h44, 1));
    vecs.push_back(mkVec(2'b11, 32'h58, 2'd1, 1, 0, 2'b00, 32'h00, 32'h00, 1));
    vecs.push_back(mkVec(2'b11, 32'h60, 2'd0, 0, 2, 2'b11, 32'h60, 32'h64, 1));

    rst = 1'b1;
    idle();
    driveLanes(2'b11, 32'h100);
    repeat (3) @(posedge clk);
    #1;
    checkState("reset", 0, 2'b00, 32'h0, 32'h0, 0);
    idle();
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", 32'(bus.ReadyF), 32'h1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkState($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expValid,
                 vecs[i].expPc0, vecs[i].expPc1, vecs[i].expReady);
    end

    // Steady push 2 / pop 2 carries both pointers around the buffer several times.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(mkVec(2'b11, 32'h68 + 32'(8*k), 2'd2, 0, 2, 2'b11,
                          32'h68 + 32'(8*k), 32'h6C + 32'(8*k), 1));
      checkOutput($sformatf("wrap%0d/count", k), 32'(bus.CountD), 32'd2);
      checkOutput($sformatf("wrap%0d/pc0", k), bus.PCD[31:0], 32'h68 + 32'(8*k));
      checkOutput($sformatf("wrap%0d/pc1", k), bus.PCD[63:32], 32'h6C + 32'(8*k));
    end

    applyStimulus(mkVec(2'b00, 32'h0, 2'd2, 0, 0, 2'b00, 32'h0, 32'h0, 1));
    checkState("drain", 0, 2'b00, 32'h0, 32'h0, 1);

    // Push into an empty queue while decode retires one lane in the same cycle.
    driveLanes(2'b11, 32'h200);
    bus.PopCntD = 2'd1;
    #1;
    checkOutput("same_cycle/ready", 32'(bus.ReadyF), 32'h1);
`ifdef FETCH_QUEUE_BYPASS_EN
    checkOutput("bypass/valid", 32'(bus.ValidD), 32'h3);
    checkOutput("bypass/pc0", bus.PCD[31:0], 32'h200);
    checkOutput("bypass/instr1", bus.InstrD[63:32], instrOf(32'h204));
`else
    checkOutput("nobypass/valid", 32'(bus.ValidD), 32'h0);
    checkOutput("nobypass/pc0", bus.PCD[31:0], 32'h0);
`endif
    @(posedge clk);
    #1;
    idle();
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    checkState("bypass_after", 1, 2'b01, 32'h204, 32'h0, 1);
`else
    checkState("nobypass_after", 2, 2'b11, 32'h200, 32'h204, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
